// File: rtl/round_timer_ctrl.sv
// Round sequencer for the math-game countdown: one-second prescaler, digit-counter
// strobes and the IDLE/LOAD/RUN/PAUSE/EXPIRED round state machine.
module round_timer_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int CNT_W         = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic       start,
    input  logic       pause,
    input  logic       answer_valid,
    input  logic [3:0] ones_digit,
    input  logic [3:0] tens_digit,
    output logic       onesec_pulse,
    output logic       reconfig,
    output logic       ones_noborrow,
    output logic       time_out,
    output logic       round_done,
    output logic       cfg_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSE   = 3'd3,
        S_EXPIRED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LP_TERMINAL = CNT_W'(TICKS_PER_SEC - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_presc_next;
    logic             r_pulse;
    logic             r_reconfig;
    logic             r_time_out;
    logic             r_round_done;
    logic             r_cfg_err;
    logic             w_pulse_next;
    logic             w_done_next;
    logic             w_err_next;
    logic             w_digits_zero;
    logic             w_digits_bad;
    logic             w_terminal;

    assign w_digits_zero = (ones_digit == 4'd0) && (tens_digit == 4'd0);
    assign w_digits_bad  = (ones_digit > 4'd9) || (tens_digit > 4'd9);
    assign w_terminal    = (r_presc == LP_TERMINAL);

    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_pulse_next = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_req) begin
                    w_state_next = S_LOAD;
                end else if (start) begin
                    if (w_digits_bad) begin
                        w_err_next = 1'b1;
                    end else if (w_digits_zero) begin
                        w_state_next = S_EXPIRED;
                    end else begin
                        w_state_next = S_RUN;
                        w_presc_next = '0;
                    end
                end
            end
            S_LOAD: begin
                if (!load_req) w_state_next = S_IDLE;
            end
            S_RUN: begin
                // Expiry outranks the tick: a terminal count on digits 00 issues no pulse.
                if (load_req) begin
                    w_state_next = S_LOAD;
                end else if (answer_valid) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else if (w_digits_zero) begin
                    w_state_next = S_EXPIRED;
                end else if (pause) begin
                    w_state_next = S_PAUSE;
                end else if (w_terminal) begin
                    w_presc_next = '0;
                    w_pulse_next = 1'b1;
                end else begin
                    w_presc_next = r_presc + 1'b1;
                end
            end
            S_PAUSE: begin
                if (load_req) begin
                    w_state_next = S_LOAD;
                end else if (answer_valid) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else if (start && !pause) begin
                    w_state_next = S_RUN;
                end
            end
            S_EXPIRED: begin
                if (load_req) w_state_next = S_LOAD;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_pulse      <= 1'b0;
            r_reconfig   <= 1'b0;
            r_time_out   <= 1'b0;
            r_round_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_presc      <= w_presc_next;
            r_pulse      <= w_pulse_next;
            r_reconfig   <= (w_state_next == S_LOAD);
            r_time_out   <= (w_state_next == S_EXPIRED);
            r_round_done <= w_done_next;
            r_cfg_err    <= w_err_next;
        end
    end

    assign onesec_pulse  = r_pulse;
    assign reconfig      = r_reconfig;
    assign time_out      = r_time_out;
    assign round_done    = r_round_done;
    assign cfg_err       = r_cfg_err;
    assign state         = r_state;
    assign ones_noborrow = (tens_digit == 4'd0);

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with TICKS_PER_SEC=4 and a small BCD
// down-counter model standing in for the ones/tens digit counters.
module tb_round_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_req = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       answer_valid = 1'b0;
    logic [3:0] ones_digit;
    logic [3:0] tens_digit;
    logic       onesec_pulse;
    logic       reconfig;
    logic       ones_noborrow;
    logic       time_out;
    logic       round_done;
    logic       cfg_err;
    logic [2:0] state;

    logic [3:0] sw_ones = 4'd0;
    logic [3:0] sw_tens = 4'd0;
    logic [3:0] m_ones = 4'd0;
    logic [3:0] m_tens = 4'd0;
    logic       f_en = 1'b0;
    logic [3:0] f_ones = 4'd0;
    logic [3:0] f_tens = 4'd0;

    int checks = 0;
    int failures = 0;

    assign ones_digit = f_en ? f_ones : m_ones;
    assign tens_digit = f_en ? f_tens : m_tens;

    round_timer_ctrl #(.TICKS_PER_SEC(4), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req     (load_req),
        .start        (start),
        .pause        (pause),
        .answer_valid (answer_valid),
        .ones_digit   (ones_digit),
        .tens_digit   (tens_digit),
        .onesec_pulse (onesec_pulse),
        .reconfig     (reconfig),
        .ones_noborrow(ones_noborrow),
        .time_out     (time_out),
        .round_done   (round_done),
        .cfg_err      (cfg_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Digit counters: load on reconfig, decrement one cycle after each tick.
    always @(posedge clk) begin
        if (reconfig) begin
            m_ones <= sw_ones;
            m_tens <= sw_tens;
        end else if (onesec_pulse) begin
            if (m_ones != 4'd0) begin
                m_ones <= m_ones - 4'd1;
            end else if (!ones_noborrow) begin
                m_ones <= 4'd9;
                m_tens <= m_tens - 4'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        sw_tens  = t;
        sw_ones  = o;
        load_req = 1'b1;
        step();
        step();
        load_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({state, onesec_pulse, reconfig, time_out, round_done, cfg_err} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {state, onesec_pulse, reconfig, time_out, round_done, cfg_err}, 8'd0);
        end
        rst = 1'b1;
        step();
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL reset_release_state got=%0d exp=0", state);
        end
        $display("test_reset done");
    endtask

    task automatic test_countdown();
        int pc;
        int p[3];
        int to_cyc;
        logic prev;
        int consec;
        pc = 0; to_cyc = -1; prev = 1'b0; consec = 0;
        p[0] = -1; p[1] = -1; p[2] = -1;
        sw_tens  = 4'd0;
        sw_ones  = 4'd3;
        load_req = 1'b1;
        step();
        checks++;
        if (reconfig !== 1'b1 || state !== 3'd1) begin
            failures++;
            $display("FAIL load_reconfig got=%b/%0d exp=1/1", reconfig, state);
        end
        step();
        load_req = 1'b0;
        step();
        checks++;
        if (reconfig !== 1'b0 || state !== 3'd0) begin
            failures++;
            $display("FAIL load_release got=%b/%0d exp=0/0", reconfig, state);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL start_run got=%0d exp=2", state);
        end
        for (int i = 1; i <= 30; i++) begin
            step();
            if (onesec_pulse) begin
                if (pc < 3) p[pc] = i;
                pc++;
                if (prev) consec++;
            end
            prev = onesec_pulse;
            if (time_out && to_cyc < 0) to_cyc = i;
        end
        checks++;
        if (pc !== 3) begin
            failures++;
            $display("FAIL countdown_pulse_count got=%0d exp=3", pc);
        end
        checks++;
        if (p[0] !== 4 || p[1] !== 8 || p[2] !== 12) begin
            failures++;
            $display("FAIL countdown_pulse_cycles got=%0d,%0d,%0d exp=4,8,12", p[0], p[1], p[2]);
        end
        checks++;
        if (consec !== 0) begin
            failures++;
            $display("FAIL countdown_consecutive_pulse got=%0d exp=0", consec);
        end
        checks++;
        if (to_cyc !== 14) begin
            failures++;
            $display("FAIL countdown_timeout_cycle got=%0d exp=14", to_cyc);
        end
        checks++;
        if (state !== 3'd4 || time_out !== 1'b1 || m_ones !== 4'd0 || m_tens !== 4'd0) begin
            failures++;
            $display("FAIL countdown_final got=state%0d to%b digits%0d%0d exp=state4 to1 digits00",
                     state, time_out, m_tens, m_ones);
        end
        $display("test_countdown pulses=%0d timeout_cycle=%0d", pc, to_cyc);
    endtask

    task automatic test_pause_resume();
        int pp;
        int first;
        pp = 0; first = -1;
        do_load(4'd1, 4'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        pause = 1'b1;
        step();
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL pause_enter got=%0d exp=3", state);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (onesec_pulse || state !== 3'd3) pp++;
        end
        checks++;
        if (pp !== 0) begin
            failures++;
            $display("FAIL pause_hold got=%0d bad_cycles exp=0", pp);
        end
        pause = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL pause_resume_state got=%0d exp=2", state);
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            if (onesec_pulse && first < 0) first = i;
        end
        checks++;
        if (first !== 2) begin
            failures++;
            $display("FAIL pause_resume_pulse got=%0d exp=2", first);
        end
        do_load(4'd0, 4'd0);
        $display("test_pause_resume first_pulse=%0d", first);
    endtask

    task automatic test_answer();
        int pp;
        pp = 0;
        do_load(4'd4, 4'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        answer_valid = 1'b1;
        step();
        answer_valid = 1'b0;
        checks++;
        if (round_done !== 1'b1 || state !== 3'd0 || time_out !== 1'b0 || onesec_pulse !== 1'b0) begin
            failures++;
            $display("FAIL answer_done got=done%b state%0d to%b pulse%b exp=done1 state0 to0 pulse0",
                     round_done, state, time_out, onesec_pulse);
        end
        step();
        checks++;
        if (round_done !== 1'b0) begin
            failures++;
            $display("FAIL answer_done_width got=%b exp=0", round_done);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (onesec_pulse || state !== 3'd0) pp++;
        end
        checks++;
        if (pp !== 0) begin
            failures++;
            $display("FAIL answer_quiet got=%0d bad_cycles exp=0", pp);
        end
        $display("test_answer done");
    endtask

    task automatic test_expiry_cfg_err();
        do_load(4'd0, 4'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (state !== 3'd4 || time_out !== 1'b1) begin
            failures++;
            $display("FAIL start_zero got=state%0d to%b exp=state4 to1", state, time_out);
        end
        start = 1'b1;
        pause = 1'b1;
        answer_valid = 1'b1;
        step();
        start = 1'b0;
        pause = 1'b0;
        answer_valid = 1'b0;
        checks++;
        if (state !== 3'd4 || time_out !== 1'b1 || round_done !== 1'b0) begin
            failures++;
            $display("FAIL expired_ignore got=state%0d to%b done%b exp=state4 to1 done0",
                     state, time_out, round_done);
        end
        sw_tens  = 4'd0;
        sw_ones  = 4'hA;
        load_req = 1'b1;
        step();
        checks++;
        if (reconfig !== 1'b1 || time_out !== 1'b0 || state !== 3'd1) begin
            failures++;
            $display("FAIL expired_load got=rc%b to%b state%0d exp=rc1 to0 state1",
                     reconfig, time_out, state);
        end
        step();
        load_req = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || state !== 3'd0) begin
            failures++;
            $display("FAIL cfg_err_pulse got=err%b state%0d exp=err1 state0", cfg_err, state);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0 || state !== 3'd0) begin
            failures++;
            $display("FAIL cfg_err_width got=err%b state%0d exp=err0 state0", cfg_err, state);
        end
        $display("test_expiry_cfg_err done");
    endtask

    task automatic test_reset_mid_run();
        int bad;
        bad = 0;
        do_load(4'd1, 4'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({state, onesec_pulse, reconfig, time_out, round_done, cfg_err} !== 8'd0) begin
            failures++;
            $display("FAIL midrun_reset_async got=%b exp=%b",
                     {state, onesec_pulse, reconfig, time_out, round_done, cfg_err}, 8'd0);
        end
        step();
        checks++;
        if (onesec_pulse !== 1'b0 || state !== 3'd0) begin
            failures++;
            $display("FAIL midrun_reset_nopulse got=pulse%b state%0d exp=pulse0 state0",
                     onesec_pulse, state);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state !== 3'd0 || onesec_pulse) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midrun_reset_idle got=%0d bad_cycles exp=0", bad);
        end
        $display("test_reset_mid_run done");
    endtask

    task automatic test_noborrow();
        f_en   = 1'b1;
        f_tens = 4'd0;
        f_ones = 4'd5;
        #1;
        checks++;
        if (ones_noborrow !== 1'b1) begin
            failures++;
            $display("FAIL noborrow_tens0 got=%b exp=1", ones_noborrow);
        end
        f_tens = 4'd3;
        #1;
        checks++;
        if (ones_noborrow !== 1'b0) begin
            failures++;
            $display("FAIL noborrow_tens3 got=%b exp=0", ones_noborrow);
        end
        f_en = 1'b0;
        $display("test_noborrow done");
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause_resume();
        test_answer();
        test_expiry_cfg_err();
        test_reset_mid_run();
        test_noborrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
